spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 target (responder) for the far end of the link driven by the project's SPI master. It oversamples `sclk`, `cs_n` and `mosi` in the `clk` domain and shifts a byte out on `miso`, MSB first. At the same time it shifts a byte in from `mosi`. A one-entry transmit holding register, with a valid/ready handshake, decouples the user logic from the SPI frame timing.

## Interface
- `WIDTH`, default 8: bits per SPI word.
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `cs_n` and `mosi`; minimum 2.
- `clk`  input  1  system clock; all logic is in this domain.
- `rst`  input  1  asynchronous, active-high reset.
- `sclk`  input  1  SPI clock from the master; idles low (CPOL=0).
- `cs_n`  input  1  SPI chip select, active low.
- `mosi`  input  1  serial data from the master.
- `miso`  output  1  serial data to the master.
- `miso_oe`  output  1  output enable for the `miso` pad; high only while the frame is selected.
- `tx_data`  input  WIDTH  next word to transmit.
- `tx_valid`  input  1  `tx_data` is valid.
- `tx_ready`  output  1  holding register is empty.
- `rx_data`  output  WIDTH  last complete received word; holds its value until the next word completes.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` updates.
- `underrun`  output  1  one-cycle pulse when a word starts with the holding register empty.
- `frame_abort`  output  1  one-cycle pulse when `cs_n` deasserts mid-word.

## Operation
- Input conditioning:
  - `sclk`, `cs_n` and `mosi` each pass through a `SYNC_STAGES` flop chain. The `cs_n` chain resets to 1; the other two reset to 0.
  - Edge detection compares the synchronized value with a one-cycle-delayed copy.
- Holding register:
  - A transfer completes when `tx_valid && tx_ready` is high at a `clk` edge; the word is captured and `hold_full` is set.
  - `tx_ready = !hold_full`.
- State machine, 2 states:
  - IDLE: `cs_n` synchronized high, `miso_oe` = 0, bit counter = 0.
  - IDLE -> SHIFT on synchronized `cs_n` falling edge:
    - If `hold_full`, the shift-out register loads the holding register and `hold_full` is cleared.
    - If not, the shift-out register loads 0 and `underrun` pulses.
    - `miso_oe` = 1 and `miso` = MSB, both from the next cycle.
  - In SHIFT, on a synchronized `sclk` rising edge:
    - `rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}`; bit counter increments.
    - When the counter reaches `WIDTH-1` before the increment, `rx_data` loads the completed word (including this bit), `rx_valid` pulses, and the counter wraps to 0.
  - In SHIFT, on a synchronized `sclk` falling edge:
    - If the counter is nonzero, shift the tx register left by one; `miso` shows the new MSB.
    - If the counter is 0 (word boundary), reload from the holding register, or load 0 and pulse `underrun`, exactly as at frame start. This supports back-to-back words within one frame.
  - SHIFT -> IDLE on synchronized `cs_n` rising edge:
    - If the counter is nonzero, the partial word is discarded: no `rx_valid`, and `frame_abort` pulses.
    - Counter is cleared; `miso_oe` = 0.
- Simultaneous events:
  - A `tx_valid` handshake in the same cycle as a load or reload: the load takes the old content. `hold_full` stays set with the new word, because set wins over clear only for the newly accepted word and `tx_ready` was high only if the register was already empty.
  - If the register was empty at a reload, `underrun` fires and the new word waits for the next boundary.
- `sclk` edges while in IDLE are ignored.
- `miso` = 0 whenever `miso_oe` = 0.

## Timing
- Reset values: `miso` = 0, `miso_oe` = 0, `tx_ready` = 1, `rx_data` = 0, `rx_valid` = 0, `underrun` = 0, `frame_abort` = 0. State is IDLE; `hold_full` = 0.
- Latency from a raw pin change to detection is `SYNC_STAGES`+1 `clk` cycles. All pulse outputs are registered and assert the cycle after detection.
- Constraints on the master's timing:
  - `sclk` high and low phases must each be at least `SYNC_STAGES`+2 `clk` periods.
  - The first `sclk` rising edge must come at least `SYNC_STAGES`+3 `clk` periods after `cs_n` falls, so MSB setup is met.
- `miso` changes only in response to a detected `cs_n` fall or `sclk` fall. It is therefore stable around `sclk` rising edges.
- Reset is asynchronous and can occur mid-frame: all state returns to reset values immediately, with no pulses on release.

## Test plan
- Single word: preload `tx_data`=0xA5; the master sends 0x3C in one 8-bit frame -> master receives 0xA5; `rx_data`=0x3C with one `rx_valid` pulse; `tx_ready` returns to 1 at frame start.
- Back-to-back words: a 16-clock frame, refilling the holding register with 0x5A after the first load -> master receives 0xA5 then 0x5A; two `rx_valid` pulses.
- Underrun: start a frame with the holding register empty -> `underrun` pulses once; master receives 0x00; `rx_data` is still captured.
- Abort: `cs_n` rises after 5 `sclk` rising edges -> `frame_abort` pulses, no `rx_valid`, `rx_data` unchanged, `miso_oe`=0. The next full frame works normally.
- Reset mid-frame: assert `rst` after 3 bits -> all outputs go to reset values asynchronously. A subsequent frame with a preload of 0xC3 transfers correctly.
- Ignore when idle: toggle `sclk` 8 times with `cs_n` high -> no pulses, `miso_oe`=0, `tx_ready` unchanged.

Source files
------------

// File: rtl/spi_target_if.sv
// spi_target_if: bundles the SPI pins and the user-side transmit/receive
// handshake of the SPI target into one interface.
//   slave  modport : the view of the SPI target itself
//   master modport : the view of whatever drives the target (SPI master
//                    plus user logic, e.g. a testbench)
// Signals:
//   sclk, cs_n, mosi        SPI pins from the master
//   miso, miso_oe           SPI data back to the master and its pad enable
//   tx_data/tx_valid/ready  one-entry transmit holding register handshake
//   rx_data/rx_valid        last complete received word and its update pulse
//   underrun, frame_abort   single-cycle status pulses
interface spi_target_if #(
  parameter int WIDTH = 8
);
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             underrun;
  logic             frame_abort;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_abort
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, frame_abort
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target. Oversamples sclk/cs_n/mosi in the clk
// domain, shifts a word out on miso MSB first while shifting a word in
// from mosi. A one-entry holding register decouples user logic from
// frame timing; back-to-back words within one frame are supported.
// Ports:
//   clk   system clock, all logic lives in this domain
//   rst   asynchronous active-high reset
//   bus   spi_target_if.slave (SPI pins plus tx/rx handshake and pulses)
module spi_target #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_target_if.slave        bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Synchronizer chains; cs_n idles high so its chain resets to 1.
  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic                   sclkDly_q;
  logic                   csDly_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       bitCnt_q;
  logic [WIDTH-1:0]       txShift_q;
  logic [WIDTH-1:0]       rxShift_q;
  logic [WIDTH-1:0]       hold_q;
  logic                   holdFull_q;
  logic                   misoOe_q;
  logic [WIDTH-1:0]       rxData_q;
  logic                   rxValid_q;
  logic                   underrun_q;
  logic                   frameAbort_q;

  logic                   sclkS;
  logic                   csS;
  logic                   mosiS;
  logic                   sclkRise;
  logic                   sclkFall;
  logic                   csFall;
  logic                   csRise;
  logic                   cntZero;
  logic                   cntLast;
  logic                   doLoad;
  logic [WIDTH-1:0]       rxWord_d;

  // Input conditioning: flop chains, then a one-cycle-delayed copy of the
  // synchronized level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclkSync_q <= '0;
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sclkDly_q  <= 1'b0;
      csDly_q    <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], bus.sclk};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
      sclkDly_q  <= sclkSync_q[SYNC_STAGES-1];
      csDly_q    <= csSync_q[SYNC_STAGES-1];
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkDly_q;
  assign sclkFall = ~sclkS & sclkDly_q;
  assign csFall   = ~csS & csDly_q;
  assign csRise   = csS & ~csDly_q;
  assign cntZero  = (bitCnt_q == '0);
  assign cntLast  = (bitCnt_q == CNT_W'(WIDTH - 1));
  assign rxWord_d = {rxShift_q[WIDTH-2:0], mosiS};

  // A word starts either at frame start or on the sclk fall that follows a
  // completed word; both take the holding register (or zero on underrun).
  assign doLoad = ((state_q == IDLE) && csFall) ||
                  ((state_q == SHIFT) && !csRise && sclkFall && cntZero);

  // Main FSM together with the holding register. The handshake only fires
  // while the register is empty and a load only clears it while it is full,
  // so a same-cycle handshake and load never fight over hold_q/holdFull_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      txShift_q    <= '0;
      rxShift_q    <= '0;
      hold_q       <= '0;
      holdFull_q   <= 1'b0;
      misoOe_q     <= 1'b0;
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      underrun_q   <= 1'b0;
      frameAbort_q <= 1'b0;
    end else begin
      rxValid_q    <= 1'b0;
      underrun_q   <= 1'b0;
      frameAbort_q <= 1'b0;

      if (bus.tx_valid && !holdFull_q) begin
        hold_q     <= bus.tx_data;
        holdFull_q <= 1'b1;
      end

      if (doLoad) begin
        if (holdFull_q) begin
          txShift_q  <= hold_q;
          holdFull_q <= 1'b0;
        end else begin
          txShift_q  <= '0;
          underrun_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_q  <= SHIFT;
            misoOe_q <= 1'b1;
            bitCnt_q <= '0;
          end
        end
        SHIFT: begin
          if (csRise) begin
            state_q      <= IDLE;
            misoOe_q     <= 1'b0;
            bitCnt_q     <= '0;
            frameAbort_q <= !cntZero;
          end else if (sclkRise) begin
            rxShift_q <= rxWord_d;
            if (cntLast) begin
              rxData_q  <= rxWord_d;
              rxValid_q <= 1'b1;
              bitCnt_q  <= '0;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end else if (sclkFall && !cntZero) begin
            txShift_q <= {txShift_q[WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.miso        = misoOe_q & txShift_q[WIDTH-1];
  assign bus.miso_oe     = misoOe_q;
  assign bus.tx_ready    = !holdFull_q;
  assign bus.rx_data     = rxData_q;
  assign bus.rx_valid    = rxValid_q;
  assign bus.underrun    = underrun_q;
  assign bus.frame_abort = frameAbort_q;

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: self-checking bench for spi_target. Acts as an SPI mode-0
// master plus user logic, and predicts every word, pulse count and register
// value from a small behavioural model of the holding register.
module tb_spi_target;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_target_if #(.WIDTH(W)) bus ();

  spi_target #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitors, only read (as deltas) by the tests.
  int rxCount = 0;
  int urCount = 0;
  int abCount = 0;

  always @(negedge clk) begin
    if (bus.rx_valid)    rxCount++;
    if (bus.underrun)    urCount++;
    if (bus.frame_abort) abCount++;
  end

  // Reference model: holding register contents and last received word.
  bit           holdFull_m = 1'b0;
  logic [W-1:0] hold_m     = '0;
  logic [W-1:0] rxData_m   = '0;

  // Offer one word for one clk cycle; the model accepts it only when empty.
  task automatic preload(input logic [W-1:0] d);
    checks++;
    if (bus.tx_ready !== !holdFull_m) begin
      errors++;
      $display("[TB] FAIL tx_ready_before_offer: got %b want %b", bus.tx_ready, !holdFull_m);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    if (!holdFull_m) begin
      holdFull_m = 1'b1;
      hold_m     = d;
    end
  endtask

  // One frame of nBits sclk periods. mosiBits holds the master's data MSB
  // first (bit i of the frame is mosiBits[31-i]). refillEn[w] offers
  // refillBytes word w during word w, after that word has been loaded.
  task automatic spiFrame(input int nBits, input logic [31:0] mosiBits,
                          input logic [31:0] refillBytes, input logic [3:0] refillEn);
    int           rx0, ur0, ab0, expUr;
    int           fullWords;
    logic [W-1:0] expTx;
    logic [W-1:0] got;
    rx0   = rxCount;
    ur0   = urCount;
    ab0   = abCount;
    expUr = 0;
    got   = '0;

    bus.cs_n = 1'b0;
    bus.mosi = mosiBits[31];
    if (holdFull_m) begin expTx = hold_m; holdFull_m = 1'b0; end
    else begin expTx = '0; expUr++; end
    repeat (HALF + 2) @(negedge clk);

    for (int i = 0; i < nBits; i++) begin
      if (i > 0) begin
        bus.sclk = 1'b0;
        bus.mosi = mosiBits[31-i];
        if (i % 8 == 0) begin
          if (holdFull_m) begin expTx = hold_m; holdFull_m = 1'b0; end
          else begin expTx = '0; expUr++; end
        end
        for (int c = 0; c < HALF; c++) begin
          if (c == 1 && (i % 8) == 2 && refillEn[i/8])
            preload(refillBytes[31-8*(i/8) -: 8]);
          else
            @(negedge clk);
        end
      end
      if (i == 0) begin
        checks++;
        if (bus.miso_oe !== 1'b1) begin
          errors++;
          $display("[TB] FAIL miso_oe_in_frame: got %b want 1", bus.miso_oe);
        end
      end
      if (i == 1) begin
        checks++;
        if (bus.tx_ready !== !holdFull_m) begin
          errors++;
          $display("[TB] FAIL tx_ready_in_frame: got %b want %b", bus.tx_ready, !holdFull_m);
        end
      end
      got      = {got[W-2:0], bus.miso};
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i % 8 == 7) begin
        checks++;
        if (got !== expTx) begin
          errors++;
          $display("[TB] FAIL miso_word%0d: got %h want %h", i / 8, got, expTx);
        end
      end
    end

    bus.cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b0;
    repeat (HALF) @(negedge clk);

    fullWords = nBits / 8;
    if (fullWords > 0) rxData_m = mosiBits[31-8*(fullWords-1) -: 8];

    checks++;
    if (rxCount - rx0 !== fullWords) begin
      errors++;
      $display("[TB] FAIL rx_valid_count: got %0d want %0d", rxCount - rx0, fullWords);
    end
    checks++;
    if (urCount - ur0 !== expUr) begin
      errors++;
      $display("[TB] FAIL underrun_count: got %0d want %0d", urCount - ur0, expUr);
    end
    checks++;
    if (abCount - ab0 !== ((nBits % 8) != 0 ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL abort_count: got %0d want %0d", abCount - ab0, (nBits % 8) != 0);
    end
    checks++;
    if (bus.rx_data !== rxData_m) begin
      errors++;
      $display("[TB] FAIL rx_data: got %h want %h", bus.rx_data, rxData_m);
    end
    checks++;
    if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_pins: got oe=%b miso=%b want 0 0", bus.miso_oe, bus.miso);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checks++;
    if (bus.miso !== 1'b0 || bus.miso_oe !== 1'b0 || bus.tx_ready !== 1'b1 ||
        bus.rx_data !== '0 || bus.rx_valid !== 1'b0 || bus.underrun !== 1'b0 ||
        bus.frame_abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: got miso=%b oe=%b rdy=%b rx=%h rv=%b ur=%b ab=%b want 0 0 1 00 0 0 0",
               tag, bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_data, bus.rx_valid,
               bus.underrun, bus.frame_abort);
    end
  endtask

  task automatic test_reset();
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_values");
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    preload(8'hA5);
    spiFrame(8, {8'h3C, 24'h0}, 32'h0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    preload(8'hA5);
    spiFrame(16, {8'h12, 8'hE7, 16'h0}, {8'h5A, 24'h0}, 4'b0001);
  endtask

  task automatic test_underrun();
    spiFrame(8, {8'h81, 24'h0}, 32'h0, 4'b0000);
  endtask

  task automatic test_abort();
    preload(8'h6B);
    spiFrame(5, {8'hF0, 24'h0}, 32'h0, 4'b0000);
    preload(8'h47);
    spiFrame(8, {8'h29, 24'h0}, 32'h0, 4'b0000);
  endtask

  task automatic test_reset_mid_frame();
    preload(8'h99);
    bus.cs_n = 1'b0;
    bus.mosi = 1'b1;
    repeat (HALF + 2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    #3 rst = 1'b1;
    #1 checkResetOutputs("async_reset_mid_frame");
    holdFull_m = 1'b0;
    rxData_m   = '0;
    bus.cs_n = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkResetOutputs("after_reset_release");
    preload(8'hC3);
    spiFrame(8, {8'h5D, 24'h0}, 32'h0, 4'b0000);
  endtask

  task automatic test_ignore_idle();
    int   rx0, ur0, ab0;
    logic rdy0;
    rx0  = rxCount; ur0 = urCount; ab0 = abCount;
    rdy0 = !holdFull_m;
    for (int i = 0; i < 8; i++) begin
      bus.sclk = 1'b1; bus.mosi = i[0];
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    checks++;
    if ((rxCount - rx0) + (urCount - ur0) + (abCount - ab0) != 0 ||
        bus.miso_oe !== 1'b0 || bus.tx_ready !== rdy0) begin
      errors++;
      $display("[TB] FAIL idle_sclk: got pulses=%0d oe=%b rdy=%b want 0 0 %b",
               (rxCount - rx0) + (urCount - ur0) + (abCount - ab0), bus.miso_oe,
               bus.tx_ready, rdy0);
    end
  endtask

  task automatic test_random();
    int          nBits;
    logic [31:0] mosiBits, refill;
    logic [3:0]  refillEn;
    for (int f = 0; f < 8; f++) begin
      nBits    = $urandom_range(1, 24);
      mosiBits = $urandom;
      refill   = $urandom;
      refillEn = 4'($urandom);
      if ($urandom_range(0, 1) == 1) preload(8'($urandom));
      spiFrame(nBits, mosiBits, refill, refillEn);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_ignore_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
